// File: rtl/cdc_filter_pkg.sv
// Shared helpers for the cdc_filter input synchroniser: the counter-width
// derivation and the packed-bus lane-slice macro.

`ifndef CDC_LANE_SLICE
// Lane idx of a bus packed as consecutive width-bit words, lane 0 in the LSBs.
`define CDC_LANE_SLICE(bus, idx, width) bus[(idx)*(width) +: (width)]
`endif

package cdc_filter_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Stability counter width: must hold 0..stable_cycles, never narrower than 1 bit.
    function automatic int cnt_width(input int stable_cycles);
        int width;
        width = clog2(stable_cycles + 1);
        return (width < 1) ? 1 : width;
    endfunction

    // Counter width for the default qualifier depth.
    localparam int CNT_WIDTH_DEFAULT = cnt_width(2);

endpackage

// File: rtl/cdc_filter_lane.sv
// One channel of cdc_filter: flip-flop synchroniser chain, stability
// qualifier and registered commit of the settled word.

module cdc_filter_lane
    import cdc_filter_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    SYNC_STAGES   = 4,
    parameter int                    STABLE_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_strobe
);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] synced;
    logic                  commit;
    logic [DATA_WIDTH-1:0] commit_value;

    assign synced = sync_q[SYNC_STAGES-1];

    // Plain shift chain: every stage only ever sees its predecessor.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= in_data;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    if (STABLE_CYCLES > 0) begin : g_qual
        localparam int                   CNT_WIDTH = cnt_width(STABLE_CYCLES);
        localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STABLE_CYCLES);
        localparam logic [CNT_WIDTH-1:0] CNT_ARM   = CNT_WIDTH'(STABLE_CYCLES - 1);

        logic [DATA_WIDTH-1:0] cand;
        logic [CNT_WIDTH-1:0]  cnt;

        // Track the most recent synced word and how long it has stayed unchanged.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                cand <= RESET_VALUE;
                cnt  <= '0;
            end else if (synced != cand) begin
                cand <= synced;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
        end

        // Commit on the edge that confirms stability, or later once saturated
        // (covers a word that settled while hold was high).
        assign commit = (cand != out_data) && !hold &&
                        (((synced == cand) && (cnt == CNT_ARM)) || (cnt == CNT_MAX));
        assign commit_value = cand;
    end else begin : g_direct
        assign commit       = (synced != out_data) && !hold;
        assign commit_value = synced;
    end

    // Registered output word and one-cycle commit strobe.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_data   <= RESET_VALUE;
            out_strobe <= 1'b0;
        end else begin
            out_strobe <= commit;
            if (commit) begin
                out_data <= commit_value;
            end
        end
    end

endmodule

// File: rtl/cdc_filter.sv
// Multi-channel input synchroniser with glitch rejection. Each channel is an
// independent cdc_filter_lane; only aclk, areset and hold are shared.

module cdc_filter
    import cdc_filter_pkg::*;
#(
    parameter int                    CHANNELS      = 2,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    SYNC_STAGES   = 4,
    parameter int                    STABLE_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           hold,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]            out_strobe
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        cdc_filter_lane #(
            .DATA_WIDTH    (DATA_WIDTH),
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE)
        ) u_lane (
            .aclk       (aclk),
            .areset     (areset),
            .hold       (hold),
            .in_data    (`CDC_LANE_SLICE(in_data, c, DATA_WIDTH)),
            .out_data   (`CDC_LANE_SLICE(out_data, c, DATA_WIDTH)),
            .out_strobe (out_strobe[c])
        );
    end

endmodule

// File: doc/cdc_filter.md
Name: cdc_filter

Overview:
- Multi-channel input synchroniser with glitch rejection for quasi-static control and status words arriving from another clock domain or from pins.
- Each channel passes through a parametrised flip-flop chain. A stability qualifier then commits a new word only after it has held constant for a set number of cycles, so a multi-bit bus is never sampled mid-transition.
- Sits at the boundary of the aclk domain and feeds configuration and status registers.
- Reports each commit with a one-cycle strobe. A hold input freezes outputs during critical sequences.

Parameters:
- CHANNELS, 2: number of independent channels.
- DATA_WIDTH, 8: width of each channel word.
- SYNC_STAGES, 4: synchroniser chain depth. Legal range is 2 or more.
- STABLE_CYCLES, 2: extra confirming cycles before a commit. 0 means commit on any synced change.
- RESET_VALUE, 0: DATA_WIDTH-bit value loaded into every register of every channel on reset.

Ports:
- aclk  in  1  single clock. All logic is clocked on its rising edge.
- areset  in  1  reset, asynchronous, active-high.
- hold  in  1  when high, commits are suppressed and out_data is frozen.
- in_data  in  CHANNELS*DATA_WIDTH  asynchronous input words. Channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_data  out  CHANNELS*DATA_WIDTH  committed words, same packing as in_data.
- out_strobe  out  CHANNELS  one-cycle pulse per channel on each commit.

Behaviour:
- Reset: while areset is high, every register holds its reset value, independent of aclk.
  - Sync chain, candidate and out_data hold RESET_VALUE.
  - Counters hold 0.
  - out_strobe holds 0.
  - Reset asserted mid-operation aborts any pending commit with no strobe.
- Sync chain, per channel: s[0] <= in_data, s[k] <= s[k-1]. The synced value is s[SYNC_STAGES-1]. The chain has no reset-to-logic shortcuts.
- Qualifier, per channel, registers cand and cnt. cnt has width clog2(STABLE_CYCLES+1) with a minimum of 1.
  - If synced != cand: cand <= synced and cnt <= 0.
  - Otherwise, if cnt < STABLE_CYCLES: cnt <= cnt + 1. cnt saturates at STABLE_CYCLES.
- Commit condition, STABLE_CYCLES > 0: synced == cand, cnt == STABLE_CYCLES-1, cand != out_data and hold == 0.
  - On commit: out_data <= cand and out_strobe <= 1 for exactly one cycle.
- Commit condition, STABLE_CYCLES == 0: cand and cnt are absent. Commit when synced != out_data and hold == 0; out_data <= synced.
- Hold release: once cnt is saturated (cnt == STABLE_CYCLES) and cand != out_data with hold == 0, the block commits on the next edge. A value that settled during hold is therefore committed one edge after hold falls.
- Latency: in_data settles before edge E1. out_data is updated and out_strobe is high after edge E(SYNC_STAGES+1+STABLE_CYCLES); with defaults that is E7.
  - Minimum pulse width for acceptance is STABLE_CYCLES+1 cycles at the synced point. Shorter excursions are dropped silently.
- Equal value: a settled value equal to the current out_data produces no strobe.
- Channel independence: channels share nothing except aclk, areset and hold. Strobes may coincide.
- No combinational path from any input to any output. out_strobe and out_data are registered.

Decomposition:
- Shared package/header holds:
  - the clog2 helper;
  - a localparam CNT_WIDTH derivation;
  - a lane-slice macro for the CHANNELS*DATA_WIDTH packing, common with other packed-bus blocks.
- One sub-module, cdc_filter_lane: one channel's sync chain, qualifier and commit logic. The top level is a generate loop over CHANNELS plus hold fan-out.

Test Plan:
- Reset: areset=1 for 3 cycles with in_data random, then pulse areset without clock -> out_data=RESET_VALUE immediately, out_strobe=0 throughout.
- Step, defaults: ch0 0x00->0xA5 before E1, held -> ch0 out_data=0xA5 and out_strobe[0]=1 for one cycle after E7. ch1 stays at 0x00 and strobe[1] stays 0.
- Glitch: ch1 0x00->0x3C for 2 cycles then back to 0x00 -> no strobe, out_data unchanged. A 3-cycle 0x3C -> commits 0x3C once.
- Bounce: ch0 alternates 0x55/0xAA every cycle for 10 cycles, then settles at 0x11 -> exactly one strobe, 7 edges after the settle edge.
- Hold: hold=1, ch0 steps to 0x42 and holds 20 cycles -> no update. Drop hold -> out_data=0x42 plus strobe one edge later. Repeat with STABLE_CYCLES=0 and SYNC_STAGES=2 -> latency 3 edges when hold is not asserted.
- Reset mid-operation: ch0 steps to 0xA5, assert areset between E4 and E5 for 2 cycles -> out_data=0x00 and no strobe. After release, with 0xA5 still applied, commit occurs 7 edges after the first post-release edge.
